// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous write port.
// Optional REGFILE_BYPASS_EN adds same-cycle write-through forwarding to both read ports.
module mips_register_file #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 5,
  parameter int unsigned          SP_INDEX = 29,
  parameter logic [DATA_W-1:0]    SP_RESET = 32'h0000_03FC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [15:0]       write_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [15:0]       write_count_q;
  logic [15:0]       write_count_d;
  logic              wr_en;

  // $zero writes are dropped entirely, so they never reach the array or the counter
  assign wr_en         = reg_write && (write_reg != '0);
  assign write_count_d = write_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == int'(SP_INDEX)) ? SP_RESET : '0;
      end
      write_count_q <= '0;
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
      write_count_q     <= write_count_d;
    end
  end

  always_comb begin
    read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
    read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !reset && (read_reg1 == write_reg)) read_data1 = write_data;
    if (wr_en && !reset && (read_reg2 == write_reg)) read_data2 = write_data;
`endif
  end

  assign write_count = write_count_q;

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.
- Sits directly downstream of the write-back selection muxes:
  - the 5-bit destination mux (rt vs rd) drives write_reg;
  - the 32-bit MemtoReg mux drives write_data.
- Two combinational read ports feed the ALU-source mux and the store-data path.
- One synchronous write port commits on the rising clock edge.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- SP_INDEX, 29, index of the stack pointer register.
- SP_RESET, 32'h0000_03FC, value loaded into register SP_INDEX on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read_reg1  input  ADDR_W  read port 1 index (rs).
- read_reg2  input  ADDR_W  read port 2 index (rt).
- write_reg  input  ADDR_W  write index, from the destination-select mux.
- write_data  input  DATA_W  write value, from the MemtoReg mux.
- reg_write  input  1  write enable from control.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.
- write_count  output  16  number of committed writes since reset (debug/verification).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, port reset: sampled only on the rising edge of clk.
- Storage: array of 2**ADDR_W registers, each DATA_W bits.
- Reset (reset=1 at a rising edge):
  - all registers clear to 0, except register SP_INDEX, which loads SP_RESET;
  - write_count clears to 0;
  - reset has priority over reg_write, so a write presented in the same cycle is discarded.
- Reset mid-operation: takes effect at the next edge regardless of pending write activity. No partial state is retained.
- Write:
  - On a rising edge with reset=0 and reg_write=1, registers[write_reg] <= write_data.
  - Latency is 1 cycle: the new value is visible on the read ports from the cycle after the edge.
- Register 0 ($zero):
  - Writes with write_reg=0 are ignored; the register always reads 0.
  - Such writes do not increment write_count.
- Read:
  - Purely combinational, 0-cycle latency.
  - read_data1 = registers[read_reg1]; read_data2 = registers[read_reg2].
  - Both ports may address the same register; both then return the same value.
- Read/write of the same index in the same cycle (build without the optional feature): the read returns the old value until the edge.
- write_count:
  - Increments by 1 on each committed write to registers 1..31.
  - Wraps from 16'hFFFF to 16'h0000 with no saturation.
- Output values after reset: read_data1 and read_data2 reflect array contents, i.e. 0 for every index except SP_INDEX, which reads SP_RESET. write_count = 0.
- X-handling: when reg_write=0, write_reg and write_data are don't-care and must not affect state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When reg_write=1, reset=0, write_reg != 0 and read_regN == write_reg, read_data N returns write_data combinationally in the same cycle. Applies independently to each port.
- Not defined: no forwarding; reads always return stored contents.
- write_count behaviour is identical in both builds.

Test Plan:
- Reset values: assert reset for 1 edge, then read every index 0..31 -> all read 0 except index 29 = 32'h0000_03FC; write_count = 0.
- Basic write/read: write reg 8 = 32'hDEAD_BEEF, reg 9 = 32'h1234_5678 on consecutive edges, then read_reg1=8, read_reg2=9 -> read_data1 = 32'hDEAD_BEEF, read_data2 = 32'h1234_5678; write_count = 2.
- $zero protection: reg_write=1, write_reg=0, write_data = 32'hFFFF_FFFF -> after the edge, reading index 0 returns 0; write_count unchanged.
- Same-cycle read/write: reg 5 holds 32'h1, then write reg 5 = 32'h2 while read_reg1=5:
  - without REGFILE_BYPASS_EN -> read_data1 = 32'h1 before the edge, 32'h2 after;
  - with REGFILE_BYPASS_EN -> read_data1 = 32'h2 in the same cycle.
- Reset vs write priority: reg 10 = 32'hAAAA_AAAA; in one cycle assert reset=1 and reg_write=1, write_reg=10, write_data = 32'h5555_5555 -> reg 10 reads 0 after the edge; write_count = 0.
- Enable gating and counter wrap:
  - reg_write=0 with write_reg=7, write_data = 32'hCAFE -> reg 7 unchanged;
  - 65536 writes to reg 3 -> write_count returns to 16'h0000.
